div_err_monitor: RTL

- Downstream consumer of the 16/8 restoring array dividers.
- Takes one approximate quotient/remainder pair and the matching exact quotient/remainder pair for the same operands on each accepted sample.
- Accumulates error statistics over a programmable window: sample count, quotient error count, remainder mismatch count, sum of error distance (ED) and maximum ED.
- Used to characterise the app_1/app_2/app_3 row configurations in silicon and in long-run simulation without dumping every result.

---
 rtl/div_err_monitor_if.sv | 15 +
 rtl/div_err_monitor.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/div_err_monitor_if.sv
// Sample channel into the divider error monitor: one approximate and one exact
// quotient/remainder pair per transfer, with a valid/ready handshake.
interface div_err_monitor_if #(
   parameter int W = 8
);
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] q_app;
   logic [W-1:0] r_app;
   logic [W-1:0] q_ex;
   logic [W-1:0] r_ex;

   modport master (output in_valid, q_app, r_app, q_ex, r_ex, input in_ready);
   modport slave  (input in_valid, q_app, r_app, q_ex, r_ex, output in_ready);
endinterface

// File: rtl/div_err_monitor.sv
// Windowed error statistics (count, quotient/remainder mismatches, error-distance
// sum and max) comparing an approximate divider against the exact one.
module div_err_monitor #(
   parameter int W     = 8,
   parameter int CNT_W = 32
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   input  logic                clear,
   input  logic [CNT_W-1:0]    win_len,
   div_err_monitor_if.slave    dif,
   output logic                busy,
   output logic                done,
   output logic [CNT_W-1:0]    smp_cnt,
   output logic [CNT_W-1:0]    qerr_cnt,
   output logic [CNT_W-1:0]    rerr_cnt,
   output logic [CNT_W-1:0]    ed_sum,
   output logic [W-1:0]        ed_max
);

   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] win_q, win_d;
   logic [CNT_W-1:0] acc_q, acc_d;
   logic [CNT_W-1:0] smp_q, smp_d;
   logic [CNT_W-1:0] qerr_q, qerr_d;
   logic [CNT_W-1:0] rerr_q, rerr_d;
   logic [CNT_W-1:0] ed_sum_q, ed_sum_d;
   logic [W-1:0]     ed_max_q, ed_max_d;
   logic [W-1:0]     s1_ed_q, s1_ed_d;
   logic             s1_qne_q, s1_qne_d;
   logic             s1_rne_q, s1_rne_d;
   logic             s1_vld_q, s1_vld_d;
   logic             done_q, done_d;
   logic [CNT_W:0]   sum_ext;
   logic             accept;

   assign dif.in_ready = (state_q == RUN) && (acc_q < win_q);
   assign accept       = dif.in_valid & dif.in_ready;

   assign busy     = (state_q == RUN);
   assign done     = done_q;
   assign smp_cnt  = smp_q;
   assign qerr_cnt = qerr_q;
   assign rerr_cnt = rerr_q;
   assign ed_sum   = ed_sum_q;
   assign ed_max   = ed_max_q;

   always_comb begin
      state_d  = state_q;
      win_d    = win_q;
      acc_d    = acc_q;
      smp_d    = smp_q;
      qerr_d   = qerr_q;
      rerr_d   = rerr_q;
      ed_sum_d = ed_sum_q;
      ed_max_d = ed_max_q;
      s1_ed_d  = s1_ed_q;
      s1_qne_d = s1_qne_q;
      s1_rne_d = s1_rne_q;
      s1_vld_d = accept;
      done_d   = 1'b0;
      sum_ext  = {1'b0, ed_sum_q} + (CNT_W+1)'(s1_ed_q);

      // Stage 1: reduce the sample to its error terms.
      if (accept) begin
         s1_ed_d  = (dif.q_app >= dif.q_ex) ? dif.q_app - dif.q_ex : dif.q_ex - dif.q_app;
         s1_qne_d = (dif.q_app != dif.q_ex);
         s1_rne_d = (dif.r_app != dif.r_ex);
         acc_d    = acc_q + CNT_W'(1);
      end

      // Stage 2: fold into the statistics; only the ED sum can overflow.
      if (s1_vld_q) begin
         smp_d    = smp_q + CNT_W'(1);
         qerr_d   = qerr_q + CNT_W'(s1_qne_q);
         rerr_d   = rerr_q + CNT_W'(s1_rne_q);
         ed_sum_d = sum_ext[CNT_W] ? '1 : sum_ext[CNT_W-1:0];
         if (s1_ed_q > ed_max_q) ed_max_d = s1_ed_q;
      end

      case (state_q)
         IDLE: begin
            if (start) begin
               state_d  = RUN;
               win_d    = win_len;
               acc_d    = '0;
               smp_d    = '0;
               qerr_d   = '0;
               rerr_d   = '0;
               ed_sum_d = '0;
               ed_max_d = '0;
            end
         end
         RUN: begin
            // Also covers an empty window: smp_d stays 0 and equals win_q.
            if (smp_d == win_q) begin
               state_d = DONE;
               done_d  = 1'b1;
            end
         end
         default: ;
      endcase

      if (clear) begin
         state_d  = IDLE;
         win_d    = '0;
         acc_d    = '0;
         smp_d    = '0;
         qerr_d   = '0;
         rerr_d   = '0;
         ed_sum_d = '0;
         ed_max_d = '0;
         s1_ed_d  = '0;
         s1_qne_d = 1'b0;
         s1_rne_d = 1'b0;
         s1_vld_d = 1'b0;
         done_d   = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         win_q    <= '0;
         acc_q    <= '0;
         smp_q    <= '0;
         qerr_q   <= '0;
         rerr_q   <= '0;
         ed_sum_q <= '0;
         ed_max_q <= '0;
         s1_ed_q  <= '0;
         s1_qne_q <= 1'b0;
         s1_rne_q <= 1'b0;
         s1_vld_q <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         win_q    <= win_d;
         acc_q    <= acc_d;
         smp_q    <= smp_d;
         qerr_q   <= qerr_d;
         rerr_q   <= rerr_d;
         ed_sum_q <= ed_sum_d;
         ed_max_q <= ed_max_d;
         s1_ed_q  <= s1_ed_d;
         s1_qne_q <= s1_qne_d;
         s1_rne_q <= s1_rne_d;
         s1_vld_q <= s1_vld_d;
         done_q   <= done_d;
      end
   end

endmodule
